// File: rtl/sdram_init_seq.sv
// sdram_init_seq: SDRAM power-up sequencer that issues controller register writes over APB and mode commands over AHB.
//   clk_i, rst_i (sync, active-high), start_i            : clock, reset, sequence trigger
//   busy_o, done_o, err_o                                : status; done_o and err_o stay set until reset
//   PSEL..PWDATA / PREADY, PSLVERR                       : APB master write port
//   HSEL..HWDATA / HREADY, HRESP                         : AHB-Lite master write port
module sdram_init_seq #(
    parameter int                    HADDR_SIZE  = 32,
    parameter int                    HDATA_SIZE  = 32,
    parameter logic [3:0]            CTRL_PADDR  = 4'h0,
    parameter logic [3:0]            TIME_PADDR  = 4'h4,
    parameter logic [31:0]           CTRL_PRE    = 32'd0,
    parameter logic [31:0]           CTRL_AREF   = 32'd1,
    parameter logic [31:0]           CTRL_LMR    = 32'd2,
    parameter logic [31:0]           CTRL_NORMAL = 32'd3,
    parameter logic [31:0]           TIME_VAL    = 32'd0,
    parameter logic [HADDR_SIZE-1:0] PRE_HADDR   = 'h400,
    parameter logic [HADDR_SIZE-1:0] AREF_HADDR  = '0,
    parameter logic [HADDR_SIZE-1:0] LMR_HADDR   = '0,
    parameter int                    AREF_CNT    = 8,
    parameter int                    TIMEOUT_CNT = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [3:0]            PADDR,
    output logic [3:0]            PSTRB,
    output logic [2:0]            PPROT,
    output logic [31:0]           PWDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic                  HSEL,
    output logic                  HWRITE,
    output logic                  HMASTLOCK,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);
    localparam int              WW        = $clog2(TIMEOUT_CNT + 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT_CNT - 1);
    localparam logic [3:0]      AREF_INIT = 4'(AREF_CNT);
    localparam logic [2:0]      ST_AREF   = 3'd3;
    localparam logic [2:0]      ST_TIME   = 3'd6;
    localparam logic [2:0]      ST_LAST   = 3'd7;

    typedef enum logic [2:0] {IDLE, APB_SETUP, APB_ACCESS, AHB_ADDR, AHB_DATA, DONE, ERROR} state_t;

    state_t                  state, state_n;
    logic [2:0]              step, step_n;
    logic [3:0]              aref, aref_n;
    logic [WW-1:0]           wait_cnt, wait_n;
    logic                    adv, timeout, apb_nx, addr_nx;
    logic [31:0]             step_data;
    logic [HADDR_SIZE-1:0]   step_haddr;

    // Steps 1, 3 and 5 are the SDRAM-side AHB writes; all others are APB register writes.
    function automatic logic is_ahb_step(input logic [2:0] s);
        return s == 3'd1 || s == ST_AREF || s == 3'd5;
    endfunction

    assign PWRITE    = 1'b1;
    assign PSTRB     = 4'hF;
    assign PPROT     = 3'b000;
    assign HWRITE    = 1'b1;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = '0;

    always_comb begin
        state_n = state;
        step_n  = step;
        aref_n  = aref;
        adv     = 1'b0;
        timeout = wait_cnt == WAIT_LAST;
        case (state)
            IDLE:       if (start_i) begin
                            step_n  = '0;
                            state_n = APB_SETUP;
                        end
            APB_SETUP:  state_n = APB_ACCESS;
            APB_ACCESS: if (PREADY) begin
                            state_n = PSLVERR ? ERROR : state;
                            adv     = !PSLVERR;
                        end else if (timeout) state_n = ERROR;
            AHB_ADDR:   if (HREADY) state_n = AHB_DATA;
                        else if (timeout) state_n = ERROR;
            AHB_DATA:   if (HREADY && HRESP) state_n = ERROR;
                        else if (HREADY) begin
                            if (step == ST_AREF) aref_n = aref - 4'd1;
                            // Refresh writes loop straight back to the address phase until the count is spent.
                            if (step == ST_AREF && aref != 4'd1) state_n = AHB_ADDR;
                            else adv = 1'b1;
                        end else if (timeout) state_n = ERROR;
            default:    ;
        endcase
        if (adv) begin
            step_n  = step + 3'd1;
            state_n = step == ST_LAST ? DONE : is_ahb_step(step + 3'd1) ? AHB_ADDR : APB_SETUP;
            if (step + 3'd1 == ST_AREF) aref_n = AREF_INIT;
        end
        wait_n = state_n != state ? '0 :
                 (state == APB_ACCESS || state == AHB_ADDR || state == AHB_DATA) ? wait_cnt + 1'b1 : wait_cnt;
        apb_nx     = state_n == APB_SETUP || state_n == APB_ACCESS;
        addr_nx    = state_n == AHB_ADDR;
        step_data  = step_n == 3'd0 ? CTRL_PRE : step_n == 3'd2 ? CTRL_AREF :
                     step_n == 3'd4 ? CTRL_LMR : step_n == ST_TIME ? TIME_VAL : CTRL_NORMAL;
        step_haddr = step_n == 3'd1 ? PRE_HADDR : step_n == ST_AREF ? AREF_HADDR : LMR_HADDR;
    end

    // Outputs are registered from the next-state view so they change together with the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            step     <= '0;
            aref     <= '0;
            wait_cnt <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            HSEL     <= 1'b0;
            HTRANS   <= 2'b00;
            HADDR    <= '0;
        end else begin
            state    <= state_n;
            step     <= step_n;
            aref     <= aref_n;
            wait_cnt <= wait_n;
            busy_o   <= !(state_n inside {IDLE, DONE, ERROR});
            done_o   <= state_n == DONE;
            err_o    <= state_n == ERROR;
            PSEL     <= apb_nx;
            PENABLE  <= state_n == APB_ACCESS;
            PADDR    <= apb_nx ? (step_n == ST_TIME ? TIME_PADDR : CTRL_PADDR) : 4'h0;
            PWDATA   <= apb_nx ? step_data : 32'd0;
            HSEL     <= addr_nx;
            HTRANS   <= addr_nx ? 2'b10 : 2'b00;
            HADDR    <= addr_nx ? step_haddr : '0;
        end
    end
endmodule

// File: tb/tb_sdram_init_seq.sv
// tb_sdram_init_seq: randomized self-checking bench for sdram_init_seq with APB/AHB slave models and a transfer-list reference.
module tb_sdram_init_seq;
    localparam logic [31:0] C_PRE  = 32'hA1;
    localparam logic [31:0] C_AREF = 32'hB2;
    localparam logic [31:0] C_LMR  = 32'hC3;
    localparam logic [31:0] C_NORM = 32'hD4;
    localparam logic [31:0] T_VAL  = 32'h5E5;
    localparam logic [31:0] PRE_A  = 32'h400;
    localparam logic [31:0] AREF_A = 32'h0;
    localparam logic [31:0] LMR_A  = 32'h230;
    localparam int          NREF   = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1, start_i = 1'b0;
    logic        busy_o, done_o, err_o;
    logic        PSEL, PENABLE, PWRITE;
    logic [3:0]  PADDR, PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PWDATA;
    logic        PREADY = 1'b1, PSLVERR = 1'b0;
    logic        HSEL, HWRITE, HMASTLOCK;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HADDR, HWDATA;
    logic        HREADY = 1'b1, HRESP = 1'b0;

    always #5 clk = ~clk;

    sdram_init_seq #(
        .CTRL_PRE(C_PRE), .CTRL_AREF(C_AREF), .CTRL_LMR(C_LMR), .CTRL_NORMAL(C_NORM), .TIME_VAL(T_VAL),
        .PRE_HADDR(PRE_A), .AREF_HADDR(AREF_A), .LMR_HADDR(LMR_A), .AREF_CNT(NREF), .TIMEOUT_CNT(256)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PSTRB(PSTRB),
        .PPROT(PPROT), .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .HSEL(HSEL), .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HADDR(HADDR), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    int          checks = 0, failures = 0;
    logic [63:0] obs_q[$], exp_q[$];
    int          pw, hw, apb_n, ahb_n, stalls, time_hold, time_acc, hresp_at, pslv_at, addr_cyc, lat;
    bit          h_hold, dphase;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rec(input bit ahb, input logic [30:0] a, input logic [31:0] d);
        return {ahb, a, d};
    endfunction

    task automatic build_exp();
        exp_q.delete();
        exp_q.push_back(rec(0, 31'h0, C_PRE));
        exp_q.push_back(rec(1, PRE_A[30:0], 32'd0));
        exp_q.push_back(rec(0, 31'h0, C_AREF));
        for (int i = 0; i < NREF; i++) exp_q.push_back(rec(1, AREF_A[30:0], 32'd0));
        exp_q.push_back(rec(0, 31'h0, C_LMR));
        exp_q.push_back(rec(1, LMR_A[30:0], 32'd0));
        exp_q.push_back(rec(0, 31'h4, T_VAL));
        exp_q.push_back(rec(0, 31'h0, C_NORM));
    endtask

    // One cycle: drive slave responses at the falling edge, then log handshakes that the next rising edge completes.
    task automatic tick();
        @(negedge clk);
        PREADY = (pw == 0) || ($urandom_range(0, pw) == 0);
        if (PSEL && PENABLE && PADDR == 4'h4 && time_hold > 0) begin
            PREADY = 1'b0;
            time_hold--;
        end
        PSLVERR = (apb_n + 1 == pslv_at);
        HREADY  = !h_hold && ((hw == 0) || ($urandom_range(0, hw) == 0));
        HRESP   = dphase && (ahb_n == hresp_at);
        if (PSEL && PENABLE && PADDR == 4'h4 && PWDATA == T_VAL) time_acc++;
        if (HSEL && HTRANS == 2'b10) addr_cyc++;
        if (PSEL && PENABLE) begin
            if (PREADY) begin
                obs_q.push_back(rec(0, 31'(PADDR), PWDATA));
                apb_n++;
            end else stalls++;
        end
        if (dphase) begin
            if (HREADY) dphase = 0;
            else stalls++;
        end
        if (HSEL && HTRANS == 2'b10) begin
            if (HREADY) begin
                obs_q.push_back(rec(1, HADDR[30:0], HWDATA));
                ahb_n++;
                dphase = 1;
            end else stalls++;
        end
    endtask

    task automatic reset_dut();
        rst_i = 1'b1; start_i = 1'b0;
        pw = 0; hw = 0; h_hold = 0; time_hold = 0; hresp_at = 0; pslv_at = 0;
        repeat (3) tick();
        rst_i = 1'b0;
        obs_q.delete();
        apb_n = 0; ahb_n = 0; dphase = 0; stalls = 0; time_acc = 0; addr_cyc = 0;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_psel"}, {PSEL, PENABLE}, 0);
        check({tag, "_paddr"}, PADDR, 0);
        check({tag, "_pwdata"}, PWDATA, 0);
        check({tag, "_hsel"}, HSEL, 0);
        check({tag, "_htrans"}, HTRANS, 0);
        check({tag, "_haddr"}, HADDR, 0);
        check({tag, "_hwdata"}, HWDATA, 0);
    endtask

    task automatic run(input int bound, output int latency);
        int n;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 1;
        check("first_busy", busy_o, 1);
        check("first_apb", {PSEL, PENABLE, PADDR}, {1'b1, 1'b0, 4'h0});
        check("first_pwdata", PWDATA, C_PRE);
        while (n < bound && !done_o && !err_o) begin
            tick();
            n++;
        end
        if (!(done_o || err_o)) check("run_bound", 0, 1);
        latency = n - 1;
    endtask

    task automatic cmp_log(input string tag, input int n);
        check({tag, "_count"}, obs_q.size(), n);
        for (int i = 0; i < n && i < obs_q.size(); i++) check({tag, "_xfer"}, obs_q[i], exp_q[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        build_exp();
        reset_dut();
        chk_reset("rst0");
        check("const", {PWRITE, PSTRB, PPROT, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK},
              {1'b1, 4'hF, 3'd0, 1'b1, 3'd2, 3'd0, 4'd3, 1'b0});

        // Zero-wait slaves: full order and 30-cycle latency.
        run(200, lat);
        check("zw_lat", lat, 30);
        cmp_log("zw", exp_q.size());
        check("zw_done", {done_o, err_o, busy_o}, 3'b100);

        // start held after completion must not launch anything.
        start_i = 1'b1;
        repeat (20) tick();
        start_i = 1'b0;
        check("hold_count", obs_q.size(), exp_q.size());
        check("hold_done", {done_o, busy_o, PSEL, HSEL}, 4'b1000);

        // TIME write held off by PREADY low for 3 cycles.
        reset_dut();
        time_hold = 3;
        run(200, lat);
        check("tw_acc", time_acc, 4);
        check("tw_lat", lat, 33);
        cmp_log("tw", exp_q.size());
        check("tw_done", done_o, 1);

        // Random wait states on both buses.
        for (int it = 0; it < 4; it++) begin
            reset_dut();
            pw = 2; hw = 2;
            run(3000, lat);
            check("rnd_lat", lat, 30 + stalls);
            cmp_log("rnd", exp_q.size());
            check("rnd_done", {done_o, err_o}, 2'b10);
        end

        // Error response on the third refresh write.
        reset_dut();
        hresp_at = 4; hw = 1;
        run(500, lat);
        repeat (20) tick();
        check("hresp_flags", {err_o, done_o, busy_o}, 3'b100);
        cmp_log("hresp", 6);
        check("hresp_idle", {PSEL, HSEL, HTRANS}, 0);

        // Slave error on the TIME register write.
        reset_dut();
        pslv_at = 4; pw = 1;
        run(500, lat);
        repeat (10) tick();
        check("pslv_flags", {err_o, done_o}, 2'b10);
        cmp_log("pslv", 14);

        // HREADY stuck low: timeout after 256 address-phase cycles.
        reset_dut();
        h_hold = 1;
        run(1000, lat);
        check("to_addr_cyc", addr_cyc, 256);
        check("to_lat", lat, 258);
        check("to_flags", {err_o, done_o, busy_o}, 3'b100);
        check("to_idle", {HTRANS, HSEL, PSEL}, 0);
        cmp_log("to", 1);

        // Reset during the fifth refresh write, then a clean restart.
        begin
            int n = 0;
            reset_dut();
            start_i = 1'b1;
            while (ahb_n < 6 && n < 300) begin
                tick();
                start_i = 1'b0;
                n++;
            end
            check("mid_reach", ahb_n, 6);
            h_hold = 1;
            tick();
            check("mid_busy", busy_o, 1);
            rst_i = 1'b1;
            tick();
            chk_reset("mid_rst");
            check("mid_count", obs_q.size(), 8);
        end
        reset_dut();
        run(200, lat);
        check("restart_lat", lat, 30);
        cmp_log("restart", exp_q.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdram_init_seq.md
SDRAM_INIT_SEQ -- requirements
Module: sdram_init_seq

Interface
REQ-001 SHALL have parameter HADDR_SIZE, 32, width of the AHB address bus.
REQ-002 SHALL have parameter HDATA_SIZE, 32, width of the AHB data bus.
REQ-003 SHALL have parameters CTRL_PADDR 4'h0 and TIME_PADDR 4'h4, the APB addresses of the CTRL and TIME registers.
REQ-004 SHALL have 32-bit parameters CTRL_PRE, CTRL_AREF, CTRL_LMR, CTRL_NORMAL and TIME_VAL, the register write values; defaults 0, 1, 2, 3 and 0.
REQ-005 SHALL have parameters PRE_HADDR 'h400 (A10 set, Precharge All), AREF_HADDR 0 and LMR_HADDR 'h0, the SDRAM-side AHB write addresses.
REQ-006 SHALL have parameter AREF_CNT, 8, 1..15, the number of AutoRefresh writes.
REQ-007 SHALL have parameter TIMEOUT_CNT, 256, the maximum wait cycles per transfer.
REQ-008 clk_i input 1: single clock for the APB and AHB sides; all logic on the rising edge.
REQ-009 rst_i input 1: reset, synchronous and active-high.
REQ-010 start_i input 1: a level high while in IDLE starts the sequence.
REQ-011 busy_o, done_o, err_o output 1 each: status (done_o and err_o are sticky).
REQ-012 PSEL, PENABLE, PWRITE output 1 each: APB master controls.
REQ-013 PADDR output 4; PSTRB output 4; PPROT output 3; PWDATA output 32.
REQ-014 PREADY and PSLVERR input 1 each.
REQ-015 HSEL, HWRITE and HMASTLOCK output 1 each.
REQ-016 HTRANS output 2; HSIZE output 3; HBURST output 3; HPROT output 4.
REQ-017 HADDR output HADDR_SIZE; HWDATA output HDATA_SIZE.
REQ-018 HREADY and HRESP input 1 each: driven from the slave's HREADYOUT and HRESP.

Function
REQ-019 Constant outputs SHALL be PWRITE=1, PSTRB=4'hF, PPROT=0, HWRITE=1, HSIZE=word (3'b010), HBURST=SINGLE, HPROT=4'b0011 and HMASTLOCK=0.
REQ-020 States SHALL be IDLE, APB_SETUP, APB_ACCESS, AHB_ADDR, AHB_DATA, DONE and ERROR; a step counter SHALL select the current operation.
REQ-021 The step order SHALL be: APB CTRL<=CTRL_PRE; AHB write PRE_HADDR; APB CTRL<=CTRL_AREF; AREF_CNT AHB writes to AREF_HADDR; APB CTRL<=CTRL_LMR; AHB write LMR_HADDR; APB TIME<=TIME_VAL; APB CTRL<=CTRL_NORMAL.
REQ-022 IDLE->first step SHALL occur on the cycle after start_i=1; busy_o=1 in every state except IDLE, DONE and ERROR.
REQ-023 APB_SETUP SHALL last exactly 1 cycle with PSEL=1, PENABLE=0 and PADDR/PWDATA valid, then go to APB_ACCESS.
REQ-024 APB_ACCESS SHALL hold PSEL=1 and PENABLE=1 with PADDR/PWDATA stable until PREADY=1; then it SHALL go to ERROR if PSLVERR=1, else to the next step.
REQ-025 AHB_ADDR SHALL drive HSEL=1, HTRANS=NONSEQ and HADDR, holding them until HREADY=1, then go to AHB_DATA.
REQ-026 AHB_DATA SHALL drive HTRANS=IDLE, HSEL=0 and HWDATA=0 until HREADY=1.
REQ-027 In AHB_DATA, HRESP=1 sampled with HREADY=1 SHALL go to ERROR.
REQ-028 In AHB_DATA, HRESP=0 sampled with HREADY=1 SHALL advance to the next step.
REQ-029 The AutoRefresh counter SHALL be 4 bits, decrement once per completed AHB write, and leave the step when it reaches 0; consecutive refresh writes SHALL be separated by exactly one AHB_DATA->AHB_ADDR edge.
REQ-030 A wait counter, sized $clog2(TIMEOUT_CNT+1) bits, SHALL clear on every state change.
REQ-031 The wait counter SHALL increment every cycle spent in APB_ACCESS, AHB_ADDR or AHB_DATA.
REQ-032 When the wait counter reaches TIMEOUT_CNT, the block SHALL go to ERROR.
REQ-033 Minimum latency SHALL be: APB step 2 cycles, AHB step 2 cycles, full sequence 2*5+2*(AREF_CNT+2) cycles from start accepted to DONE.
REQ-034 DONE SHALL set done_o=1 and ERROR SHALL set err_o=1; both SHALL be held until rst_i.
REQ-035 start_i SHALL be ignored in every state except IDLE.
REQ-036 ERROR SHALL drive PSEL=0 and HTRANS=IDLE; a bus transfer abandoned by timeout is not retried.

Reset
REQ-037 While rst_i=1 sampled, the state SHALL be IDLE and all counters 0.
REQ-038 While rst_i=1, outputs SHALL be busy_o=done_o=err_o=0, PSEL=PENABLE=0, PADDR=0, PWDATA=0, HSEL=0, HTRANS=IDLE, HADDR=0 and HWDATA=0.
REQ-039 rst_i asserted mid-sequence SHALL abort the sequence within one cycle, even during an APB or AHB wait, and SHALL NOT complete the pending transfer.

Verification
REQ-040 Zero-wait slaves, start_i pulse -> 5 APB writes and 10 AHB writes in REQ-021 order; done_o=1 exactly 30 cycles after start is sampled.
REQ-041 PREADY held low 3 cycles on the TIME write -> PADDR=4'h4 and PWDATA=TIME_VAL stable for 4 access cycles; sequence completes with done_o=1.
REQ-042 HRESP=1 on the 3rd AutoRefresh write -> err_o=1, done_o=0, and no further APB/AHB transfers.
REQ-043 HREADY held low for 256 cycles in AHB_ADDR -> err_o=1 on cycle 256 and HTRANS=IDLE afterwards.
REQ-044 rst_i pulsed during the 5th refresh write, then start_i -> outputs at reset values, then the sequence restarts from CTRL<=CTRL_PRE.
REQ-045 start_i held high after DONE -> no new transfers; done_o stays 1.
